multdiv_sequencer: RTL and testbench

- Sequences the multi-cycle HI/LO instruction class (MULT/MULTU, MUL, MADD/MADDU/MSUB/MSUBU, DIV/DIVU, MTHI/MTLO) for the execute stage.
- Owns the architectural HI/LO registers.
- Accepts one request at a time with a valid/ready handshake and holds busy while an operation is in flight, so the pipeline can stall MFHI/MFLO/MUL consumers.
- A flush input aborts in-flight work without committing on exception or ERET.

---
 rtl/decode_pkg.sv | 19 +
 rtl/multdiv_pkg.sv | 41 ++++
 rtl/multdiv_div_radix2.sv | 85 ++++++++
 rtl/multdiv_sequencer.sv | 167 ++++++++++++++++
 tb/tb_multdiv_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Decoded opcode space shared with the decode stage.
// Only the HI/LO-class encodings matter to the multiply/divide sequencer.
package decode_pkg;
    typedef enum logic [6:0] {
        OP_NOP   = 7'd0,
        OP_ADD   = 7'd1,
        OP_MULT  = 7'd8,
        OP_MULTU = 7'd9,
        OP_MUL   = 7'd10,
        OP_MADD  = 7'd11,
        OP_MADDU = 7'd12,
        OP_MSUB  = 7'd13,
        OP_MSUBU = 7'd14,
        OP_DIV   = 7'd16,
        OP_DIVU  = 7'd17,
        OP_MTHI  = 7'd20,
        OP_MTLO  = 7'd21
    } decoded_op_t;
endpackage

// File: rtl/multdiv_pkg.sv
// Types and the opcode classifier shared by the HI/LO sequencer and its divider.
package multdiv_pkg;
    import decode_pkg::*;

    localparam int MD_DIV_ITERS = 32;

    typedef enum logic [2:0] {
        ST_IDLE, ST_MUL, ST_DIV_ABS, ST_DIV_ITER, ST_DIV_FIX
    } md_state_t;

    typedef enum logic [1:0] {MD_NONE, MD_MT, MD_MUL, MD_DIV} md_kind_t;

    typedef struct packed {
        md_kind_t kind;
        logic     sgn;      // signed operands
        logic     acc;      // accumulate into {hi,lo}
        logic     sub;      // accumulate by subtraction
        logic     lo_only;  // MUL: result to mul_result, HI/LO untouched
        logic     to_hi;    // MTHI rather than MTLO
    } md_class_t;

    function automatic md_class_t md_classify(input decoded_op_t op);
        md_class_t c;
        c = '0;
        case (op)
            OP_MULT:  begin c.kind = MD_MUL; c.sgn = 1'b1; end
            OP_MULTU: c.kind = MD_MUL;
            OP_MUL:   begin c.kind = MD_MUL; c.sgn = 1'b1; c.lo_only = 1'b1; end
            OP_MADD:  begin c.kind = MD_MUL; c.sgn = 1'b1; c.acc = 1'b1; end
            OP_MADDU: begin c.kind = MD_MUL; c.acc = 1'b1; end
            OP_MSUB:  begin c.kind = MD_MUL; c.sgn = 1'b1; c.acc = 1'b1; c.sub = 1'b1; end
            OP_MSUBU: begin c.kind = MD_MUL; c.acc = 1'b1; c.sub = 1'b1; end
            OP_DIV:   begin c.kind = MD_DIV; c.sgn = 1'b1; end
            OP_DIVU:  c.kind = MD_DIV;
            OP_MTHI:  begin c.kind = MD_MT; c.to_hi = 1'b1; end
            OP_MTLO:  c.kind = MD_MT;
            default:  ;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/multdiv_div_radix2.sv
// Unsigned restoring divider, one quotient bit per cycle. The first step is
// taken on the start edge so the result is ready ITERS cycles after start.
module div_radix2 #(
    parameter int W     = 32,
    parameter int ITERS = W
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         valid
);
    localparam int CW = $clog2(ITERS + 1);

    logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d, valid_q, valid_d;
    logic [W-1:0]  r_src, q_src, d_src, r_nx, q_nx;
    logic [W:0]    trial;

    always_comb begin
        r_src = start ? '0 : rem_q;
        q_src = start ? dividend : quo_q;
        d_src = start ? divisor : dvs_q;
        trial = {r_src, q_src[W-1]} - {1'b0, d_src};
        if (!trial[W]) begin
            r_nx = trial[W-1:0];
            q_nx = {q_src[W-2:0], 1'b1};
        end else begin
            r_nx = {r_src[W-2:0], q_src[W-1]};
            q_nx = {q_src[W-2:0], 1'b0};
        end

        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        valid_d = 1'b0;
        if (abort) begin
            run_d = 1'b0;
        end else if (start) begin
            rem_d   = r_nx;
            quo_d   = q_nx;
            dvs_d   = divisor;
            cnt_d   = CW'(ITERS - 1);
            run_d   = (ITERS > 1);
            valid_d = (ITERS == 1);
        end else if (run_q) begin
            rem_d = r_nx;
            quo_d = q_nx;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                run_d   = 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            valid_q <= valid_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign valid     = valid_q;
endmodule

// File: rtl/multdiv_sequencer.sv
// HI/LO multiply/divide sequencer for the execute stage. Owns HI/LO, runs one
// op at a time, and commits only if no flush arrives before the commit edge.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int MUL_CYCLES = 3,
    parameter int DIV_ITERS  = MD_DIV_ITERS
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] mul_result,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);
    localparam int CW = $clog2(MUL_CYCLES + 1);

    md_state_t     state_q, state_d;
    md_class_t     cls_q, cls_d, cls_in;
    logic [31:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, mres_q, mres_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          qneg_q, qneg_d, rneg_q, rneg_d;
    logic          done_q, done_d, zpend_q, zpend_d;
    logic          accept, div_start, div_valid;
    logic [63:0]   a_ext, b_ext, prod, acc_res;
    logic [31:0]   a_abs, b_abs, div_q, div_r;

    div_radix2 #(.W(32), .ITERS(DIV_ITERS)) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .abort     (flush),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .quotient  (div_q),
        .remainder (div_r),
        .valid     (div_valid)
    );

    always_comb begin
        cls_in  = md_classify(decode_pkg::decoded_op_t'(req_op));
        accept  = req_valid && (state_q == ST_IDLE) && !flush;
        a_ext   = {{32{cls_q.sgn & a_q[31]}}, a_q};
        b_ext   = {{32{cls_q.sgn & b_q[31]}}, b_q};
        prod    = a_ext * b_ext;
        acc_res = !cls_q.acc ? prod :
                  cls_q.sub  ? {hi_q, lo_q} - prod : {hi_q, lo_q} + prod;
        a_abs   = (cls_q.sgn && a_q[31]) ? -a_q : a_q;
        b_abs   = (cls_q.sgn && b_q[31]) ? -b_q : b_q;

        state_d   = state_q;
        cls_d     = cls_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mres_d    = mres_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        done_d    = 1'b0;
        zpend_d   = 1'b0;
        div_start = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A zero-divisor DIV returns to IDLE one cycle before its done pulse.
                    done_d = zpend_q;
                    if (accept) begin
                        cls_d = cls_in;
                        a_d   = req_a;
                        b_d   = req_b;
                        case (cls_in.kind)
                            MD_MT: begin
                                if (cls_in.to_hi) hi_d = req_a;
                                else              lo_d = req_a;
                                done_d = 1'b1;
                            end
                            MD_MUL: begin
                                state_d = ST_MUL;
                                cnt_d   = CW'(MUL_CYCLES - 1);
                            end
                            MD_DIV:  state_d = ST_DIV_ABS;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt_q == '0) begin
                        if (cls_q.lo_only) mres_d = prod[31:0];
                        else               {hi_d, lo_d} = acc_res;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DIV_ABS: begin
                    if (b_q == '0) begin
                        zpend_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        div_start = 1'b1;
                        qneg_d    = cls_q.sgn & (a_q[31] ^ b_q[31]);
                        rneg_d    = cls_q.sgn & a_q[31];
                        state_d   = ST_DIV_ITER;
                    end
                end
                ST_DIV_ITER: if (div_valid) state_d = ST_DIV_FIX;
                ST_DIV_FIX: begin
                    lo_d    = qneg_q ? -div_q : div_q;
                    hi_d    = rneg_q ? -div_r : div_r;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cls_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mres_q  <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            done_q  <= 1'b0;
            zpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mres_q  <= mres_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            done_q  <= done_d;
            zpend_q <= zpend_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign mul_result = mres_q;
    assign hi_out     = hi_q;
    assign lo_out     = lo_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: latency, HI/LO arithmetic, divide corners,
// flush suppression and asynchronous reset, with hand-computed expectations.
module tb_multdiv_sequencer;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, flush;
    logic        req_ready, busy, done;
    logic [6:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [31:0] mul_result, hi_out, lo_out;

    int checks   = 0;
    int failures = 0;

    multdiv_sequencer #(.MUL_CYCLES(3), .DIV_ITERS(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .mul_result (mul_result),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    always #5 clk = ~clk;

    // Present a request for one edge; returns 1ns after the accept edge.
    task automatic issue(input decoded_op_t op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Edges after the accept edge until done is seen; -1 if it never shows.
    task automatic wait_done(input int limit, output int lat);
        lat = -1;
        for (int k = 0; k < limit; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        checks++; if (hi_out !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", hi_out, 32'h0); end
        checks++; if (lo_out !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", lo_out, 32'h0); end
        checks++; if ({req_ready, busy, done} !== 3'b100) begin failures++; $display("FAIL reset_ctl got=%b exp=100", {req_ready, busy, done}); end
        checks++; if (mul_result !== 32'h0) begin failures++; $display("FAIL reset_mres got=%h exp=0", mul_result); end
    endtask

    task automatic test_mult;
        int lat;
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        checks++; if ({req_ready, busy} !== 2'b01) begin failures++; $display("FAIL mult_busy got=%b exp=01", {req_ready, busy}); end
        wait_done(10, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL mult_latency got=%0d exp=3", lat); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mult_ready got=%b exp=1", req_ready); end
        checks++; if ({hi_out, lo_out} !== 64'hFFFF_FFFF_FFFF_FFFA) begin failures++; $display("FAIL mult_hilo got=%h exp=%h", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFA); end
    endtask

    task automatic test_accumulate;
        int lat;
        issue(OP_MTHI, 32'h0, 32'h0);
        wait_done(5, lat);
        checks++; if (lat !== 0 || hi_out !== 32'h0) begin failures++; $display("FAIL mthi got_lat=%0d got_hi=%h exp_lat=0 exp_hi=0", lat, hi_out); end
        issue(OP_MTLO, 32'h1, 32'h0);
        wait_done(5, lat);
        checks++; if (lat !== 0 || lo_out !== 32'h1) begin failures++; $display("FAIL mtlo got_lat=%0d got_lo=%h exp_lat=0 exp_lo=1", lat, lo_out); end
        // 0xFFFFFFFF*2 = 0x1_FFFFFFFE, plus 1
        issue(OP_MADDU, 32'hFFFF_FFFF, 32'd2);
        wait_done(10, lat);
        checks++; if (lat !== 3 || {hi_out, lo_out} !== 64'h1_FFFF_FFFF) begin failures++; $display("FAIL maddu got_lat=%0d got=%h exp=%h", lat, {hi_out, lo_out}, 64'h1_FFFF_FFFF); end
        issue(OP_MSUB, 32'd1, 32'd1);
        wait_done(10, lat);
        checks++; if ({hi_out, lo_out} !== 64'h1_FFFF_FFFE) begin failures++; $display("FAIL msub got=%h exp=%h", {hi_out, lo_out}, 64'h1_FFFF_FFFE); end
    endtask

    task automatic test_div;
        int lat;
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(60, lat);
        checks++; if (lat !== 34) begin failures++; $display("FAIL div_latency got=%0d exp=34", lat); end
        checks++; if (lo_out !== 32'hFFFF_FFFD || hi_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_signed got_lo=%h got_hi=%h exp_lo=fffffffd exp_hi=ffffffff", lo_out, hi_out); end
        issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
        wait_done(60, lat);
        checks++; if (lat !== 34 || lo_out !== 32'h7FFF_FFFC || hi_out !== 32'h1) begin failures++; $display("FAIL divu got_lat=%0d got_lo=%h got_hi=%h exp_lat=34 exp_lo=7ffffffc exp_hi=1", lat, lo_out, hi_out); end
    endtask

    task automatic test_div_corners;
        int lat;
        issue(OP_MTLO, 32'h1234, 32'h0);
        wait_done(5, lat);
        issue(OP_DIV, 32'd99, 32'd0);
        wait_done(60, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL div0_latency got=%0d exp=2", lat); end
        checks++; if (lo_out !== 32'h1234 || hi_out !== 32'h1) begin failures++; $display("FAIL div0_hilo got_lo=%h got_hi=%h exp_lo=1234 exp_hi=1", lo_out, hi_out); end
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(60, lat);
        checks++; if (lat !== 34 || lo_out !== 32'h8000_0000 || hi_out !== 32'h0) begin failures++; $display("FAIL div_ovf got_lat=%0d got_lo=%h got_hi=%h exp_lat=34 exp_lo=80000000 exp_hi=0", lat, lo_out, hi_out); end
    endtask

    task automatic test_flush;
        int lat;
        int seen;
        issue(OP_MTHI, 32'hAAAA, 32'h0);
        wait_done(5, lat);
        issue(OP_MTLO, 32'h5555, 32'h0);
        wait_done(5, lat);
        // flush on the tenth edge of a divide
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        checks++; if ({req_ready, busy, done} !== 3'b100) begin failures++; $display("FAIL flush_div_ctl got=%b exp=100", {req_ready, busy, done}); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        checks++; if (seen !== 0 || hi_out !== 32'hAAAA || lo_out !== 32'h5555) begin failures++; $display("FAIL flush_div_commit got_dones=%0d got_hi=%h got_lo=%h exp_dones=0 exp_hi=aaaa exp_lo=5555", seen, hi_out, lo_out); end
        // flush on the MUL commit edge (third edge after accept)
        issue(OP_MULT, 32'd5, 32'd5);
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (done === 1'b1) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0 || req_ready !== 1'b1 || hi_out !== 32'hAAAA || lo_out !== 32'h5555) begin failures++; $display("FAIL flush_mul_commit got_dones=%0d got_ready=%b got_hi=%h got_lo=%h exp 0/1/aaaa/5555", seen, req_ready, hi_out, lo_out); end
        // flush together with a request: nothing accepted
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; req_op = OP_MTHI; req_a = 32'hDEAD;
        @(posedge clk);
        #1 req_valid = 1'b0; flush = 1'b0;
        checks++; if (hi_out !== 32'hAAAA || done !== 1'b0) begin failures++; $display("FAIL flush_mt_accept got_hi=%h got_done=%b exp_hi=aaaa exp_done=0", hi_out, done); end
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; req_op = OP_MULT; req_a = 32'd3; req_b = 32'd3;
        @(posedge clk);
        #1 req_valid = 1'b0; flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_mul_accept got_busy=%b exp=0", busy); end
    endtask

    task automatic test_mul_low;
        int lat;
        issue(OP_MUL, 32'd7, 32'hFFFF_FFFD);
        wait_done(10, lat);
        checks++; if (lat !== 3 || mul_result !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_neg got_lat=%0d got=%h exp_lat=3 exp=ffffffeb", lat, mul_result); end
        issue(OP_MUL, 32'h1_0000, 32'h1_0000);
        wait_done(10, lat);
        checks++; if (lat !== 3 || mul_result !== 32'h0) begin failures++; $display("FAIL mul_wrap got_lat=%0d got=%h exp_lat=3 exp=0", lat, mul_result); end
        checks++; if (hi_out !== 32'hAAAA || lo_out !== 32'h5555) begin failures++; $display("FAIL mul_hilo got_hi=%h got_lo=%h exp_hi=aaaa exp_lo=5555", hi_out, lo_out); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || mul_result !== 32'h0) begin failures++; $display("FAIL mul_hold got_done=%b got=%h exp_done=0 exp=0", done, mul_result); end
    endtask

    task automatic test_noop;
        int lat;
        issue(OP_ADD, 32'd1, 32'd2);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL noop_ready got=%b exp=1", req_ready); end
        wait_done(6, lat);
        checks++; if (lat !== -1 || hi_out !== 32'hAAAA || lo_out !== 32'h5555) begin failures++; $display("FAIL noop_effect got_lat=%0d got_hi=%h got_lo=%h exp_lat=-1", lat, hi_out, lo_out); end
    endtask

    task automatic test_reset_mid_div;
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++; if (hi_out !== 32'h0 || lo_out !== 32'h0 || mul_result !== 32'h0) begin failures++; $display("FAIL rst_mid_data got_hi=%h got_lo=%h got_mres=%h exp=0", hi_out, lo_out, mul_result); end
        checks++; if ({req_ready, busy, done} !== 3'b100) begin failures++; $display("FAIL rst_mid_ctl got=%b exp=100", {req_ready, busy, done}); end
        @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0 || lo_out !== 32'h0) begin failures++; $display("FAIL rst_mid_after got_done=%b got_lo=%h exp 0/0", done, lo_out); end
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        flush     = 1'b0;
        req_op    = OP_NOP;
        req_a     = '0;
        req_b     = '0;
        #23;
        test_reset;
        @(negedge clk);
        resetn = 1'b1;
        test_mult;
        test_accumulate;
        test_div;
        test_div_corners;
        test_flush;
        test_mul_low;
        test_noop;
        test_reset_mid_div;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
